// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU fetch and load/store ports.
// One shared single-ported RAM, fixed access latency, data port wins over
// instruction port. Faults (out of range, store to text, ld+st together)
// respond one cycle after accept with rdata forced to 0 and a sticky segv flag.
// Optional: define MEM_RESPONDER_FAULT_CNT_EN to add a saturating fault_count.
module mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int TEXT_TOP   = 256,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr_rdata,
  output logic              wait_instr,
  output logic              instr_segv,
  input  logic              data_ld,
  input  logic              data_st,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              wait_data,
`ifdef MEM_RESPONDER_FAULT_CNT_EN
  output logic              data_segv,
  output logic [7:0]        fault_count
`else
  output logic              data_segv
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    port_q;   // 1 = data port, 0 = instruction port
  logic                    ld_q, st_q, fault_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       instr_rdata_q, data_rdata_q;
  logic                    instr_segv_q, data_segv_q;
`ifdef MEM_RESPONDER_FAULT_CNT_EN
  logic [7:0]              fault_cnt_q;
`endif

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic data_req, any_req;
  logic instr_oor, data_oor, data_fault, acc_fault;
  logic enter_resp;
  logic cur_port, cur_ld, cur_fault;
  logic [DEPTH_LOG2-1:0] cur_idx;

  assign data_req  = data_ld | data_st;
  assign any_req   = data_req | instr_req;
  assign instr_oor = (instr_addr >> DEPTH_LOG2) != '0;
  assign data_oor  = (data_addr >> DEPTH_LOG2) != '0;
  assign data_fault = data_oor | (data_st & (32'(data_addr) < TEXT_TOP)) | (data_ld & data_st);
  assign acc_fault  = data_req ? data_fault : instr_oor;

  // Response is entered straight from IDLE (fault or single-cycle latency)
  // or when the ACCESS countdown reaches 1.
  assign enter_resp = ((state_q == IDLE) && any_req && (acc_fault || (LATENCY == 1))) ||
                      ((state_q == ACCESS) && (cnt_q == 4'd1));

  // Transaction attributes for the response being entered: taken live from
  // the ports on the accept cycle, otherwise from the latched copy.
  always_comb begin
    cur_port  = port_q;
    cur_ld    = ld_q;
    cur_fault = fault_q;
    cur_idx   = idx_q;
    if (state_q == IDLE) begin
      cur_port  = data_req;
      cur_ld    = data_req ? data_ld : 1'b1;
      cur_fault = acc_fault;
      cur_idx   = data_req ? data_addr[DEPTH_LOG2-1:0] : instr_addr[DEPTH_LOG2-1:0];
    end
  end

  // Main FSM with registered read data and sticky fault flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      port_q        <= 1'b0;
      ld_q          <= 1'b0;
      st_q          <= 1'b0;
      fault_q       <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
      instr_segv_q  <= 1'b0;
      data_segv_q   <= 1'b0;
`ifdef MEM_RESPONDER_FAULT_CNT_EN
      fault_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          port_q  <= data_req;
          ld_q    <= cur_ld;
          st_q    <= data_req & data_st;
          fault_q <= acc_fault;
          idx_q   <= cur_idx;
          wdata_q <= data_wdata;
          if (data_req) data_segv_q  <= 1'b0;
          else          instr_segv_q <= 1'b0;
          if (acc_fault || (LATENCY == 1)) state_q <= RESP;
          else begin
            state_q <= ACCESS;
            cnt_q   <= LAT_M1;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase

      // Later assignments override the accept-time clear of the segv flag.
      if (enter_resp) begin
        if (cur_port) begin
          if (cur_ld) data_rdata_q <= cur_fault ? '0 : mem[cur_idx];
          if (cur_fault) data_segv_q <= 1'b1;
        end else begin
          instr_rdata_q <= cur_fault ? '0 : mem[cur_idx];
          if (cur_fault) instr_segv_q <= 1'b1;
        end
`ifdef MEM_RESPONDER_FAULT_CNT_EN
        if (cur_fault && (fault_cnt_q != 8'hFF)) fault_cnt_q <= fault_cnt_q + 8'd1;
`endif
      end
    end
  end

  // Store commits at the end of the RESP cycle so a reset there aborts it.
  always_ff @(posedge clk) begin
    if (reset_n && (state_q == RESP) && port_q && st_q && !fault_q)
      mem[idx_q] <= wdata_q;
  end

  assign wait_instr  = instr_req & ~((state_q == RESP) & ~port_q);
  assign wait_data   = data_req  & ~((state_q == RESP) &  port_q);
  assign instr_rdata = instr_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign instr_segv  = instr_segv_q;
  assign data_segv   = data_segv_q;
`ifdef MEM_RESPONDER_FAULT_CNT_EN
  assign fault_count = fault_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters).
module tb_mem_responder;

  logic        clk, reset_n;
  logic        instr_req;
  logic [15:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        wait_instr, instr_segv;
  logic        data_ld, data_st;
  logic [15:0] data_addr;
  logic [31:0] data_wdata, data_rdata;
  logic        wait_data, data_segv;
`ifdef MEM_RESPONDER_FAULT_CNT_EN
  logic [7:0]  fault_count;
`endif

  int tests = 0;
  int fails = 0;

  mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
    .wait_instr(wait_instr), .instr_segv(instr_segv),
    .data_ld(data_ld), .data_st(data_st), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .wait_data(wait_data),
`ifdef MEM_RESPONDER_FAULT_CNT_EN
    .data_segv(data_segv), .fault_count(fault_count)
`else
    .data_segv(data_segv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one data request and hold it until wait_data drops (bounded).
  task automatic do_data(input logic ld, input logic st, input logic [15:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic sv, output int lat);
    data_ld = ld; data_st = st; data_addr = a; data_wdata = wd; lat = 0;
    #1;
    while (wait_data && lat < 20) begin tick(); lat++; end
    rd = data_rdata; sv = data_segv;
    data_ld = 1'b0; data_st = 1'b0;
    tick();
  endtask

  task automatic do_fetch(input logic [15:0] a, output logic [31:0] rd,
                          output logic sv, output int lat);
    instr_req = 1'b1; instr_addr = a; lat = 0;
    #1;
    while (wait_instr && lat < 20) begin tick(); lat++; end
    rd = instr_rdata; sv = instr_segv;
    instr_req = 1'b0;
    tick();
  endtask

  logic [31:0] rd, old40;
  logic        sv;
  int          lat;

  initial begin
    reset_n = 1'b0; instr_req = 1'b0; instr_addr = '0;
    data_ld = 1'b0; data_st = 1'b0; data_addr = '0; data_wdata = '0;
    tick(); tick(); tick();
    check("rst_irdata", instr_rdata, 32'h0);
    check("rst_drdata", data_rdata, 32'h0);
    check("rst_segv", {30'b0, instr_segv, data_segv}, 32'h0);
    check("rst_wait", {30'b0, wait_instr, wait_data}, 32'h0);
    reset_n = 1'b1;
    tick();

    // store then load back
    do_data(1'b0, 1'b1, 16'h0300, 32'hDEADBEEF, rd, sv, lat);
    check("st300_lat", lat, 2);
    check("st300_segv", {31'b0, sv}, 0);
    do_data(1'b1, 1'b0, 16'h0300, 32'h0, rd, sv, lat);
    check("ld300_lat", lat, 2);
    check("ld300_data", rd, 32'hDEADBEEF);
    check("ld300_segv", {31'b0, sv}, 0);

    // fetch of the stored word
    do_fetch(16'h0300, rd, sv, lat);
    check("if300_lat", lat, 2);
    check("if300_data", rd, 32'hDEADBEEF);

    // simultaneous fetch and load: data first, fetch accepted after
    do_data(1'b0, 1'b1, 16'h0310, 32'h12345678, rd, sv, lat);
    instr_req = 1'b1; instr_addr = 16'h0010;
    data_ld = 1'b1; data_addr = 16'h0310;
    #1;
    check("sim_T0", {30'b0, wait_instr, wait_data}, 32'h3);
    tick();
    check("sim_T1", {30'b0, wait_instr, wait_data}, 32'h3);
    tick();
    check("sim_T2", {30'b0, wait_instr, wait_data}, 32'h2);
    check("sim_drdata", data_rdata, 32'h12345678);
    tick(); data_ld = 1'b0; #1;
    check("sim_T3", {31'b0, wait_instr}, 1);
    tick();
    check("sim_T4", {31'b0, wait_instr}, 1);
    tick();
    check("sim_T5", {31'b0, wait_instr}, 0);
    check("sim_isegv", {31'b0, instr_segv}, 0);
    instr_req = 1'b0;
    tick();

    // store into text region faults and leaves RAM alone
    do_data(1'b1, 1'b0, 16'h0040, 32'h0, old40, sv, lat);
    do_data(1'b0, 1'b1, 16'h0040, 32'hAAAA5555, rd, sv, lat);
    check("sttext_lat", lat, 1);
    check("sttext_segv", {31'b0, sv}, 1);
    tick();
    check("sttext_sticky", {31'b0, data_segv}, 1);
    do_data(1'b1, 1'b0, 16'h0040, 32'h0, rd, sv, lat);
    check("ld40_unchanged", rd, old40);
    check("ld40_segv_clr", {31'b0, sv}, 0);

    // out-of-range fetch, ld+st together
    do_fetch(16'h0400, rd, sv, lat);
    check("if400_lat", lat, 1);
    check("if400_segv", {31'b0, sv}, 1);
    check("if400_data", rd, 32'h0);
    do_data(1'b1, 1'b1, 16'h0300, 32'h55555555, rd, sv, lat);
    check("ldst_lat", lat, 1);
    check("ldst_segv", {31'b0, sv}, 1);
    check("isegv_sticky", {31'b0, instr_segv}, 1);
    do_data(1'b1, 1'b0, 16'h0300, 32'h0, rd, sv, lat);
    check("ldst_nowrite", rd, 32'hDEADBEEF);

    // reset during ACCESS of a store aborts the write
    do_data(1'b0, 1'b1, 16'h0320, 32'h11112222, rd, sv, lat);
    data_st = 1'b1; data_addr = 16'h0320; data_wdata = 32'h99999999;
    #1;
    tick();
    reset_n = 1'b0; data_st = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("rstacc_drdata", data_rdata, 32'h0);
    check("rstacc_segv", {30'b0, instr_segv, data_segv}, 32'h0);
    check("rstacc_irdata", instr_rdata, 32'h0);
    do_data(1'b1, 1'b0, 16'h0320, 32'h0, rd, sv, lat);
    check("rstacc_lat", lat, 2);
    check("rstacc_ram", rd, 32'h11112222);

`ifdef MEM_RESPONDER_FAULT_CNT_EN
    for (int i = 0; i < 300; i++) do_fetch(16'h0800, rd, sv, lat);
    check("fcnt_sat", {24'b0, fault_count}, 32'd255);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("fcnt_rst", {24'b0, fault_count}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU control path's instruction-fetch and data (load/store) requests.
- Generates `wait_instr`/`wait_data` back-pressure, returns read data, and raises `instr_segv`/`data_segv` faults that feed the controller's trap logic.
- Single-ported word-addressed backing RAM shared by both request ports, with fixed access latency and data-over-instruction arbitration.

Parameters:
- ADDR_W, 16, word address width of both ports
- DATA_W, 32, data word width
- DEPTH_LOG2, 10, log2 of RAM words; addresses with any bit set at or above DEPTH_LOG2 are out of range
- TEXT_TOP, 256, word addresses below this are read-only text; stores there fault
- LATENCY, 2, cycles from accept to response; legal range 1..15

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- instr_req  in  1  fetch request, held high until wait_instr low
- instr_addr  in  ADDR_W  fetch word address, stable while instr_req high
- instr_rdata  out  DATA_W  fetched word, valid in response cycle
- wait_instr  out  1  fetch not yet complete
- instr_segv  out  1  sticky fetch fault
- data_ld  in  1  load request
- data_st  in  1  store request
- data_addr  in  ADDR_W  data word address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load result, valid in response cycle
- wait_data  out  1  data access not yet complete
- data_segv  out  1  sticky data fault

Behaviour:
- Reset: reset_n is a synchronous, active-low reset; clock is clk.
  - State IDLE; latency counter 0; instr_rdata, data_rdata, instr_segv and data_segv are 0.
  - RAM contents are not cleared.
  - Reset during ACCESS or RESP aborts the transaction and performs no write.
- States: IDLE, ACCESS, RESP.
- IDLE accepts one request per cycle:
  - A pending data request (data_ld|data_st) beats instr_req.
  - On accept, latch port, address, operation and wdata, and evaluate the fault.
  - Accepting clears that port's segv flag.
- Data fault if any of:
  - address out of range;
  - data_st with addr < TEXT_TOP;
  - data_ld and data_st both high.
- Instruction fault: address out of range.
- Transitions:
  - Faulting accept goes IDLE->RESP directly (response next cycle).
  - Non-faulting accept with LATENCY=1 also goes IDLE->RESP.
  - Otherwise go to ACCESS with counter=LATENCY-1; decrement each cycle; at 1 go to RESP.
  - RESP always goes to IDLE.
- Latency: request accepted at cycle T responds at cycle T+LATENCY. A faulting request responds at T+1.
- RESP cycle:
  - The served port's wait is low.
  - Load/fetch: rdata is registered with the RAM word. On fault, rdata is 0.
  - Store: the RAM write commits this cycle, only if no fault.
  - The segv flag sets this cycle on fault and holds until that port's next accept.
- Wait outputs are combinational:
  - wait_instr = instr_req & ~(RESP & port==instr).
  - wait_data = (data_ld|data_st) & ~(RESP & port==data).
- Requester must deassert its request in the cycle after the response. Otherwise IDLE treats it as a new request.
- A request dropped mid-ACCESS still completes, including any store; the response is discarded.
- rdata holds its value until the next response on the same port.
- Simultaneous instr_req and data request in IDLE: data served first. The instruction port keeps wait_instr high and is accepted at the next IDLE cycle after the data RESP.

Optional Feature:
- MEM_RESPONDER_FAULT_CNT_EN defined:
  - Adds output fault_count [7:0].
  - fault_count is a saturating count of faulting responses on both ports, incremented in RESP when a fault is returned.
  - Reset to 0; holds at 255.
- Undefined: the port and counter are absent; behaviour otherwise identical.

Test Plan:
- LATENCY=2; store 0xDEADBEEF to data_addr 0x300, then load 0x300 -> wait_data high 1 cycle after each accept; data_rdata=0xDEADBEEF in the load response cycle; data_segv=0.
- instr_req and data_ld raised together, addrs 0x10/0x310 -> data responds at T+2, instruction accepted T+3, responds T+5; wait_instr high throughout T..T+4.
- Store to addr 0x0040 (< TEXT_TOP) -> response at T+1, data_segv=1, RAM[0x40] unchanged on readback; next good load clears data_segv.
- Fetch from 0x0400 with DEPTH_LOG2=10 -> instr_segv=1 at T+1, instr_rdata=0; data_ld and data_st both high -> data_segv=1.
- reset_n low during ACCESS of a store to 0x320 -> outputs 0, state IDLE, RAM[0x320] retains its old value.
- With MEM_RESPONDER_FAULT_CNT_EN: 300 faulting fetches -> fault_count=255; reset -> 0.
